// File: rtl/onehot_seq_encoder_pkg.sv
// Shared definitions for the one-hot sequence encoder: default widths and
// the two-state FSM encoding.
package onehot_pkg;

   // Default request-vector width and the index width derived from it.
   localparam int N_DEF = 4;
   localparam int W_DEF = $clog2(N_DEF);

   // IDLE waits for a vector; EMIT drains the pending bits lowest first.
   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

endpackage : onehot_pkg

// File: rtl/onehot_seq_encoder_if.sv
// Handshake bundle between the request source, the encoder and the index
// consumer. The slave modport is the encoder's view; master is the
// environment driving requests and accepting indices.
interface onehot_seq_encoder_if
   import onehot_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = $clog2(N)
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_vec;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic         out_last;
   logic         err_zero;
   logic         busy;

   modport slave (
      input  in_valid, in_vec, out_ready,
      output in_ready, out_valid, out_idx, out_last, err_zero, busy
   );

   modport master (
      output in_valid, in_vec, out_ready,
      input  in_ready, out_valid, out_idx, out_last, err_zero, busy
   );
endinterface : onehot_seq_encoder_if

// File: rtl/onehot_seq_encoder_lsb_index.sv
// Combinational lowest-set-bit locator: binary index of the lowest set bit
// plus a flag telling whether that bit is the only one set.
module lsb_index
   import onehot_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] vec_i,
   output logic [W-1:0] idx_o,
   output logic         single_o
);

   logic [N-1:0] vec_m1;

   // vec & (vec-1) clears the lowest set bit; nothing left means one bit.
   assign vec_m1   = vec_i - {{(N-1){1'b0}}, 1'b1};
   assign single_o = (|vec_i) && !(|(vec_i & vec_m1));

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o = W'(i);
         end
      end
   end

endmodule : lsb_index

// File: rtl/onehot_seq_encoder.sv
// Captures a request vector and emits the binary index of each set bit,
// lowest first, one per output handshake. A new vector is accepted only
// after the previous one has fully drained.
module onehot_seq_encoder
   import onehot_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   onehot_seq_encoder_if.slave   bus
);

   state_t       state_q, state_d;
   logic [N-1:0] pending_q, pending_d;
   logic         err_q, err_d;

   logic [W-1:0] lsb_idx;
   logic         lsb_single;
   logic [N-1:0] clr_mask;

   // Index and last flag depend only on pending, so they hold under backpressure.
   lsb_index #(
      .N (N),
      .W (W)
   ) u_lsb (
      .vec_i    (pending_q),
      .idx_o    (lsb_idx),
      .single_o (lsb_single)
   );

   assign clr_mask     = {{(N-1){1'b0}}, 1'b1} << lsb_idx;
   assign bus.err_zero = err_q;

   // State, pending vector and zero-vector pulse register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q;
      err_d         = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_idx   = '0;
      bus.out_last  = 1'b0;
      bus.busy      = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               if (|bus.in_vec) begin
                  pending_d = bus.in_vec;
                  state_d   = EMIT;
               end else begin
                  // All-zero vector is consumed but produces nothing.
                  err_d = 1'b1;
               end
            end
         end
         EMIT: begin
            bus.out_valid = 1'b1;
            bus.busy      = 1'b1;
            bus.out_idx   = lsb_idx;
            bus.out_last  = lsb_single;
            if (bus.out_ready) begin
               pending_d = pending_q & ~clr_mask;
               if (lsb_single) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            pending_d = '0;
         end
      endcase
   end

endmodule : onehot_seq_encoder

// File: tb/tb_onehot_seq_encoder.sv
// Bench for onehot_seq_encoder: a scoreboard queue holds the expected
// {last, idx} of every emission, pushed when a vector is driven and popped
// by a monitor on each output handshake; direct checks cover reset values,
// latency, backpressure, zero vectors, input during EMIT and mid-run reset.
module tb_onehot_seq_encoder;
   import onehot_pkg::*;

   localparam int N = 4;
   localparam int W = 2;

   logic clk;
   logic rst_n;

   onehot_seq_encoder_if #(.N(N), .W(W)) bus ();

   onehot_seq_encoder #(.N(N), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [W:0] exp_q [$];
   logic mon_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Monitor: on each handshake about to occur, compare against the scoreboard.
   always @(negedge clk) begin
      if (mon_en && rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_emit", {29'd0, bus.out_last, bus.out_idx}, 32'hFFFF);
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            chk("sb_idx", 32'(bus.out_idx), 32'(e[W-1:0]));
            chk("sb_last", 32'(bus.out_last), 32'(e[W]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference expectation: indices ascending, last on the highest set bit.
   task automatic push_exp(input logic [N-1:0] vec);
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            logic [N-1:0] hi;
            hi = vec >> (i + 1);
            exp_q.push_back({(hi == '0), W'(i)});
         end
      end
   endtask

   task automatic send(input logic [N-1:0] vec);
      int n = 0;
      while (!bus.in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
      bus.in_valid = 1'b1;
      bus.in_vec   = vec;
      push_exp(vec);
      tick();
      bus.in_valid = 1'b0;
      bus.in_vec   = '0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
         tick();
         n++;
      end
      chk("drain_timeout", 32'(n < 100), 1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      chk({tag, "_out_idx"}, 32'(bus.out_idx), 0);
      chk({tag, "_out_last"}, 32'(bus.out_last), 0);
      chk({tag, "_err_zero"}, 32'(bus.err_zero), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_vec    = '0;
      bus.out_ready = 1'b0;
      #12;
      chk_reset_vals("rst");
      tick();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      tick();

      // 1: single bit, latency one cycle after accept
      bus.out_ready = 1'b1;
      send(4'b0100);
      chk("t1_out_valid", 32'(bus.out_valid), 1);
      chk("t1_idx", 32'(bus.out_idx), 2);
      chk("t1_last", 32'(bus.out_last), 1);
      chk("t1_busy", 32'(bus.busy), 1);
      chk("t1_in_ready_busy", 32'(bus.in_ready), 0);
      tick();
      chk("t1_in_ready_back", 32'(bus.in_ready), 1);
      chk("t1_out_valid_low", 32'(bus.out_valid), 0);

      // 2: full vector, consecutive emissions
      send(4'b1111);
      tick(); tick(); tick();
      chk("t2_last_on_3", {30'd0, bus.out_last, bus.out_valid}, 32'h3);
      chk("t2_idx3", 32'(bus.out_idx), 3);
      chk("t2_in_ready_busy", 32'(bus.in_ready), 0);
      tick();
      chk("t2_in_ready_back", 32'(bus.in_ready), 1);
      chk("t2_sb_empty", 32'(exp_q.size()), 0);

      // 3: backpressure holds index and last flag
      bus.out_ready = 1'b0;
      send(4'b1010);
      for (int c = 0; c < 5; c++) begin
         chk("t3_hold_valid", 32'(bus.out_valid), 1);
         chk("t3_hold_idx", 32'(bus.out_idx), 1);
         chk("t3_hold_last", 32'(bus.out_last), 0);
         tick();
      end
      bus.out_ready = 1'b1;
      drain();

      // 4: zero vector dropped with a one-cycle error pulse
      send(4'b0000);
      chk("t4_err_pulse", 32'(bus.err_zero), 1);
      chk("t4_out_valid", 32'(bus.out_valid), 0);
      chk("t4_in_ready", 32'(bus.in_ready), 1);
      tick();
      chk("t4_err_clear", 32'(bus.err_zero), 0);
      chk("t4_out_valid2", 32'(bus.out_valid), 0);

      // 5: a vector offered during EMIT waits until the block is idle
      send(4'b0011);
      bus.in_valid = 1'b1;
      bus.in_vec   = 4'b1000;
      push_exp(4'b1000);
      chk("t5_in_ready_busy", 32'(bus.in_ready), 0);
      tick();
      chk("t5_idx1", 32'(bus.out_idx), 1);
      tick();
      chk("t5_in_ready_idle", 32'(bus.in_ready), 1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_vec   = '0;
      chk("t5_idx3", 32'(bus.out_idx), 3);
      drain();

      // 6: asynchronous reset in the middle of a drain
      send(4'b1110);
      tick();
      chk("t6_idx2", 32'(bus.out_idx), 2);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("t6_rst");
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("t6_no_resume", 32'(bus.out_valid), 0);
      end
      chk("final_sb_empty", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_onehot_seq_encoder

// File: doc/onehot_seq_encoder.md
Name: onehot_seq_encoder

Overview:
- Inverse of the team's 2-to-4 decoder: takes a captured request bit-vector and emits the binary index of every set bit, lowest index first, one index per output handshake.
- Sits between request sources, such as interrupt or grant lines, and consumers that want binary codes.
- Uses valid/ready handshakes on both sides and accepts a new vector only after the previous one is fully drained.

Parameters:
- N, 4, width of the request vector; must be at least 2.
- W, $clog2(N), width of the emitted index (2 when N=4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_vec is presented.
- in_ready  output  1  block can accept in_vec.
- in_vec  input  N  request bit-vector.
- out_valid  output  1  out_idx holds a valid index.
- out_ready  input  1  consumer accepts out_idx.
- out_idx  output  W  binary index of the lowest pending bit.
- out_last  output  1  out_idx is the final index of the current vector.
- err_zero  output  1  one-cycle pulse: an all-zero vector was accepted and dropped.
- busy  output  1  pending vector is non-zero (state EMIT).

Behaviour:
- Single clock domain. Reset is asynchronous, active-low.
- Reset values:
  - pending = 0, state = IDLE.
  - in_ready = 1, out_valid = 0, out_idx = 0, out_last = 0, err_zero = 0, busy = 0.
- Internal state: N-bit register pending; FSM with states IDLE and EMIT.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_vec != 0 at a clock edge: pending <= in_vec, go to EMIT.
  - On in_valid && in_vec == 0: the vector is accepted and discarded; err_zero = 1 for the following cycle; stay in IDLE.
- EMIT:
  - in_ready = 0, out_valid = 1, busy = 1.
  - out_idx = position of the lowest set bit of pending.
  - out_last = 1 when pending has exactly one bit set.
  - out_idx and out_last are pure functions of the pending register, so they are stable while out_valid && !out_ready.
  - On out_valid && out_ready: that bit of pending is cleared. If out_last, go to IDLE (pending becomes 0). Otherwise stay in EMIT, and the next index appears the following cycle.
- Latency:
  - Accept edge k: out_valid is high in cycle k+1.
  - A vector with P set bits needs at least P output cycles.
  - After the last handshake, in_ready rises the next cycle. There is no same-cycle accept on drain, so the minimum period per vector is P+1 cycles.
- Boundary conditions:
  - in_valid while in EMIT: ignored (in_ready = 0). The source must hold in_vec.
  - All N bits set: emits 0, 1, ..., N-1; out_last only with N-1.
  - Only bit N-1 set: single emission idx = N-1, out_last = 1.
  - Backpressure (out_ready held low indefinitely): pending, out_idx and out_last hold unchanged.
  - Reset mid-EMIT: pending cleared immediately, outputs return to reset values, no partial emission resumes.
  - out_ready high in IDLE: no effect.
- Width rule: out_idx is zero-extended to W bits. When N is not a power of 2, indices ≥ N never appear.

Decomposition:
- Package onehot_pkg:
  - default N, W derivation.
  - FSM state typedef (IDLE = 1'b0, EMIT = 1'b1).
- Sub-module lsb_index (combinational):
  - input N-bit vector; outputs W-bit lowest-set-bit index and a single_bit flag.
  - Instantiated once on pending.
- Top level holds the FSM, the pending register and the handshakes.

Test Plan:
1. Reset, then single bit: in_vec = 4'b0100 with out_ready = 1 → next cycle out_idx = 2, out_last = 1; then IDLE, in_ready = 1.
2. Full vector: in_vec = 4'b1111, out_ready = 1 → out_idx sequence 0, 1, 2, 3 on consecutive cycles; out_last only with 3; in_ready returns the cycle after.
3. Backpressure: in_vec = 4'b1010, out_ready = 0 for 5 cycles → out_idx = 1 held stable, out_last = 0. Then out_ready = 1 → idx 1, then idx 3 with out_last = 1.
4. Zero vector: in_valid with in_vec = 4'b0000 → err_zero pulses for 1 cycle, out_valid stays 0, in_ready stays 1.
5. Input during EMIT: in_vec = 4'b0011 accepted; then in_valid with 4'b1000 while busy → ignored. Output is exactly idx 0, 1; 4'b1000 is accepted only once in_ready = 1 again.
6. Reset mid-operation: in_vec = 4'b1110, one handshake (idx 1), then assert rst_n = 0 asynchronously between edges → outputs return to reset values at once; after release, no further indices appear.
